// File: rtl/sr_bank_pkg.sv
// Shared opcodes, FSM states and opcode classification for the SR bank controller.
// COUNT_DN_EN enables op 111 as a down-counter; without it op 111 is undefined.
package sr_bank_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP    = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD   = 3'b001;
    localparam logic [OP_W-1:0] OP_SET    = 3'b010;
    localparam logic [OP_W-1:0] OP_CLEAR  = 3'b011;
    localparam logic [OP_W-1:0] OP_TOGGLE = 3'b100;
    localparam logic [OP_W-1:0] OP_RSVD   = 3'b101;
    localparam logic [OP_W-1:0] OP_CNT_UP = 3'b110;
    localparam logic [OP_W-1:0] OP_CNT_DN = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_COUNT = 2'd2
    } state_t;

    // Ops that step the bank over several cycles.
    function automatic logic op_is_count(input logic [OP_W-1:0] op);
`ifdef COUNT_DN_EN
        return (op == OP_CNT_UP) || (op == OP_CNT_DN);
`else
        return (op == OP_CNT_UP);
`endif
    endfunction

    function automatic logic op_is_defined(input logic [OP_W-1:0] op);
`ifdef COUNT_DN_EN
        return (op != OP_RSVD);
`else
        return (op != OP_RSVD) && (op != OP_CNT_DN);
`endif
    endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR flip-flop with synchronous reset value; s=r=1 holds the current value.
module sr_cell #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= RESET_VAL;
            qb <= ~RESET_VAL;
        end else if (s && !r) begin
            q  <= 1'b1;
            qb <= 1'b0;
        end else if (r && !s) begin
            q  <= 1'b0;
            qb <= 1'b1;
        end
    end

endmodule

// File: rtl/sr_bank_ctrl.sv
// Command sequencer operating a bank of SR cells as a register / counter.
// COUNT_DN_EN adds the down-count op (111).
module sr_bank_ctrl
    import sr_bank_pkg::*;
#(
    parameter int unsigned     WIDTH     = 4,
    parameter int unsigned     CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    state_t             state, state_nxt;
    logic [OP_W-1:0]    op_q;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   rem, rem_nxt;
    logic               accept, step, done_nxt, err_nxt, count_dn, carry;
    logic [WIDTH-1:0]   t, s_bus, r_bus;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        accept    = 1'b0;
        step      = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept = 1'b1;
                    if (op_is_count(cmd_op)) begin
                        state_nxt = ST_COUNT;
                        rem_nxt   = cmd_data[CNT_W-1:0];
                    end else begin
                        state_nxt = ST_APPLY;
                    end
                end
            end
            ST_APPLY: begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
                err_nxt   = !op_is_defined(op_q);
            end
            ST_COUNT: begin
                // A stop or an exhausted count ends without applying a step.
                if (stop || rem == CNT_W'(0)) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    step    = 1'b1;
                    rem_nxt = rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_NOP;
            data_q    <= '0;
            rem       <= '0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
            end
            rem       <= rem_nxt;
            done      <= done_nxt;
            cmd_err   <= err_nxt;
            cmd_ready <= (state_nxt == ST_IDLE);
            busy      <= (state_nxt != ST_IDLE);
        end
    end

`ifdef COUNT_DN_EN
    assign count_dn = (op_q == OP_CNT_DN);
`else
    assign count_dn = 1'b0;
`endif

    // Ripple toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        s_bus = '0;
        r_bus = '0;
        t     = '0;
        carry = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            t[i]  = carry;
            carry = carry & (count_dn ? qb[i] : q[i]);
        end
        if (state == ST_APPLY) begin
            case (op_q)
                OP_LOAD: begin
                    s_bus = data_q;
                    r_bus = ~data_q;
                end
                OP_SET:    s_bus = data_q;
                OP_CLEAR:  r_bus = data_q;
                OP_TOGGLE: begin
                    s_bus = data_q & qb;
                    r_bus = data_q & q;
                end
                default: ;
            endcase
        end else if (step) begin
            s_bus = t & qb;
            r_bus = t & q;
        end
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        sr_cell #(.RESET_VAL(RESET_VAL[i])) u_cell (
            .clk (clk),
            .rst (rst),
            .s   (s_bus[i]),
            .r   (r_bus[i]),
            .q   (q[i]),
            .qb  (qb[i])
        );
    end

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Self-checking bench for sr_bank_ctrl: directed steps plus random commands vs. an integer model.
// Build with +define+COUNT_DN_EN to cover the down-count op.
module tb_sr_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic       stop;
    logic [3:0] q;
    logic [3:0] qb;
    logic       busy;
    logic       done;
    logic       cmd_err;

    int         vectors = 0;
    int         miscompares = 0;
    logic [3:0] model;

    always #5 clk = ~clk;

    sr_bank_ctrl #(.WIDTH(4), .CNT_W(4), .RESET_VAL(4'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .stop      (stop),
        .q         (q),
        .qb        (qb),
        .busy      (busy),
        .done      (done),
        .cmd_err   (cmd_err)
    );

    task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // No cell may ever be driven with S and R together.
    always @(negedge clk) begin
        vectors++;
        assert ((dut.s_bus & dut.r_bus) === 4'h0) else begin
            miscompares++;
            $error("FAIL s_and_r: observed s=%h r=%h expected no overlap", dut.s_bus, dut.r_bus);
        end
    end

    // Issue one command from IDLE and check it cycle by cycle against the model.
    // stop_cyc: 1-based count cycle in which stop is raised (0 = never).
    // b2b: present the command in the cycle where the previous done is still high.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] data,
                           input int stop_cyc, input bit b2b);
        bit is_cnt, is_dn, err, fin;
        int n, c;
        is_dn = 1'b0;
`ifdef COUNT_DN_EN
        is_dn = (op == 3'd7);
`endif
        is_cnt = (op == 3'd6) || is_dn;
        err    = (op == 3'd5) || ((op == 3'd7) && !is_dn);
        n      = int'(data);
        if (!b2b) begin
            @(negedge clk);
            chk1("done_pulse_end", done, 1'b0);
        end
        chk1("ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = 4'($urandom);
        if (is_cnt) begin
            c   = 1;
            fin = 1'b0;
            while (!fin) begin
                chk4("cnt_q", q, model);
                chk1("cnt_done", done, 1'b0);
                if (n != 0) begin
                    chk1("cnt_busy", busy, 1'b1);
                    chk1("cnt_ready", cmd_ready, 1'b0);
                end
                if (c == stop_cyc) stop = 1'b1;
                if (c == stop_cyc || n == 0) begin
                    fin = 1'b1;
                end else begin
                    model = is_dn ? model - 4'd1 : model + 4'd1;
                    if (c == n) fin = 1'b1;
                end
                @(negedge clk);
                stop = 1'b0;
                c++;
            end
        end else begin
            chk1("apply_busy", busy, 1'b1);
            chk1("apply_ready", cmd_ready, 1'b0);
            chk1("apply_done", done, 1'b0);
            chk4("apply_q_old", q, model);
            case (op)
                3'd1: model = data;
                3'd2: model = model | data;
                3'd3: model = model & ~data;
                3'd4: model = model ^ data;
                default: ;
            endcase
            @(negedge clk);
        end
        chk4("q", q, model);
        chk4("qb", qb, ~model);
        chk1("done", done, 1'b1);
        chk1("cmd_err", cmd_err, err);
        chk1("busy_end", busy, 1'b0);
        chk1("ready_end", cmd_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        int op_i, st;
        logic [3:0] d;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 4'd0;
        stop      = 1'b0;
        model     = 4'h0;
        repeat (3) @(negedge clk);
        chk4("rst_q", q, 4'h0);
        chk4("rst_qb", qb, 4'hF);
        chk1("rst_ready", cmd_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", cmd_err, 1'b0);
        rst = 1'b0;

        run_cmd(3'd1, 4'hA, 0, 1'b0);   // LOAD 0xA
        run_cmd(3'd2, 4'h5, 0, 1'b0);   // SET -> 0xF
        run_cmd(3'd3, 4'h3, 0, 1'b0);   // CLEAR -> 0xC
        run_cmd(3'd4, 4'h9, 0, 1'b0);   // TOGGLE -> 0x5
        run_cmd(3'd1, 4'hD, 0, 1'b0);
        run_cmd(3'd6, 4'd4, 0, 1'b0);   // D -> E,F,0,1
        chk4("count_wrap_result", q, 4'h1);
        run_cmd(3'd1, 4'h0, 0, 1'b1);   // accepted while done is high
        run_cmd(3'd6, 4'd10, 3, 1'b0);  // stop in 3rd cycle -> 0x2
        chk4("stop_result", q, 4'h2);
        run_cmd(3'd6, 4'd0, 0, 1'b0);   // n=0: no change
        run_cmd(3'd5, 4'h7, 0, 1'b0);   // reserved op
        run_cmd(3'd0, 4'hF, 0, 1'b1);   // NOP
        run_cmd(3'd1, 4'h1, 0, 1'b0);
        run_cmd(3'd7, 4'd3, 0, 1'b0);   // down 1->0,F,E with macro, else cmd_err
`ifdef COUNT_DN_EN
        chk4("count_dn_result", q, 4'hE);
`else
        chk4("op7_nop_result", q, 4'h1);
`endif

        // Reset in the middle of a COUNT.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd6;
        cmd_data  = 4'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model = 4'h0;
        chk4("midrst_q", q, 4'h0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_done", done, 1'b0);
        chk1("midrst_ready", cmd_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk1("midrst_no_done", done, 1'b0);
        chk4("midrst_q_hold", q, 4'h0);

        for (int k = 0; k < 60; k++) begin
            op_i = int'($urandom_range(0, 7));
            d    = 4'($urandom);
            st   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 17)) : 0;
            run_cmd(3'(op_i), d, st, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
